// File: rtl/issue_queue_pkg.sv
// Shared bus widths and entry layout for the issue queue.
// Also carries the shared PC/DECODEOUT bus definitions.
`ifndef ISSUE_QUEUE_DEF_VH
`define ISSUE_QUEUE_DEF_VH
`define PC_BUS 31:0
`define DECODEOUT_BUS 63:0
`endif

package issue_queue_pkg;

  typedef struct packed {
    logic [`PC_BUS]        pc;
    logic [`PC_BUS]        npc;
    logic [`DECODEOUT_BUS] decodeout;
  } iq_entry_t;

  localparam int unsigned ENTRY_W = $bits(iq_entry_t);

  // Launch may report 3; the queue never offers more than two entries.
  function automatic logic [1:0] clip_pop(input logic [1:0] n);
    return (n == 2'd3) ? 2'd2 : n;
  endfunction

endpackage

// File: rtl/iq_entry_mem.sv
// Issue queue entry storage: two write ports, two asynchronous read ports.
// No reset; validity is tracked entirely by the pointer/count logic.
module iq_entry_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 128,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we0_i,
  input  logic [AW-1:0]    waddr0_i,
  input  logic [WIDTH-1:0] wdata0_i,
  input  logic             we1_i,
  input  logic [AW-1:0]    waddr1_i,
  input  logic [WIDTH-1:0] wdata1_i,
  input  logic [AW-1:0]    raddr0_i,
  output logic [WIDTH-1:0] rdata0_o,
  input  logic [AW-1:0]    raddr1_i,
  output logic [WIDTH-1:0] rdata1_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/issue_queue.sv
// Dual-issue circular instruction queue between decode and launch.
// Optional same-cycle bypass when empty: define ISSUE_QUEUE_BYPASS_EN.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in1_valid,
  input  logic                  in2_valid,
  input  logic [`PC_BUS]        in1_pc,
  input  logic [`PC_BUS]        in1_npc,
  input  logic [`PC_BUS]        in2_pc,
  input  logic [`PC_BUS]        in2_npc,
  input  logic [`DECODEOUT_BUS] in1_decodeout,
  input  logic [`DECODEOUT_BUS] in2_decodeout,
  output logic                  in_ready,
  output logic [`PC_BUS]        out1_pc,
  output logic [`PC_BUS]        out1_npc,
  output logic [`PC_BUS]        out2_pc,
  output logic [`PC_BUS]        out2_npc,
  output logic [`DECODEOUT_BUS] out1_decodeout,
  output logic [`DECODEOUT_BUS] out2_decodeout,
  output logic                  receive_flag1,
  output logic                  receive_flag2,
  input  logic [1:0]            pop_num,
  input  logic                  stop,
  input  logic                  flush
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [1:0] push_num, pop_req, pop_eff, bp_pop, wr_num, avail;
  logic       rf1, rf2, bp_active;
  iq_entry_t  in1_e, in2_e, rd1_e, rd2_e, out1_e, out2_e, wr0_e;

  assign in1_e = '{pc: in1_pc, npc: in1_npc, decodeout: in1_decodeout};
  assign in2_e = '{pc: in2_pc, npc: in2_npc, decodeout: in2_decodeout};

  assign in_ready = (count_q <= CW'(DEPTH - 2));

  always_comb begin
    if (!in_ready || flush || !in1_valid) push_num = 2'd0;
    else                                  push_num = in2_valid ? 2'd2 : 2'd1;
  end

  always_comb begin
    bp_active = 1'b0;
    rf1       = (count_q != '0);
    rf2       = (count_q >= CW'(2));
    out1_e    = rd1_e;
    out2_e    = rd2_e;
`ifdef ISSUE_QUEUE_BYPASS_EN
    if (count_q == '0 && !flush) begin
      bp_active = 1'b1;
      rf1       = (push_num != 2'd0);
      rf2       = (push_num == 2'd2);
      out1_e    = in1_e;
      out2_e    = in2_e;
    end
`endif
    avail   = {1'b0, rf1} + {1'b0, rf2};
    pop_req = clip_pop(pop_num);
    pop_eff = (stop || flush) ? 2'd0 : ((pop_req < avail) ? pop_req : avail);
    // Bypassed entries consumed this cycle are never written; survivors
    // shift down to the first write port.
    bp_pop  = bp_active ? pop_eff : 2'd0;
    wr_num  = push_num - bp_pop;
    wr0_e   = (bp_pop == 2'd1) ? in2_e : in1_e;
  end

  always_comb begin
    head_d  = head_q + PW'(pop_eff - bp_pop);
    tail_d  = tail_q + PW'(wr_num);
    count_d = count_q + CW'(push_num) - CW'(pop_eff);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  iq_entry_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk_i    (clk),
    .we0_i    (rst && (wr_num != 2'd0)),
    .waddr0_i (tail_q),
    .wdata0_i (wr0_e),
    .we1_i    (rst && (wr_num == 2'd2)),
    .waddr1_i (tail_q + PW'(1)),
    .wdata1_i (in2_e),
    .raddr0_i (head_q),
    .rdata0_o (rd1_e),
    .raddr1_i (head_q + PW'(1)),
    .rdata1_o (rd2_e)
  );

  assign receive_flag1  = rf1;
  assign receive_flag2  = rf2;
  assign out1_pc        = rf1 ? out1_e.pc        : '0;
  assign out1_npc       = rf1 ? out1_e.npc       : '0;
  assign out1_decodeout = rf1 ? out1_e.decodeout : '0;
  assign out2_pc        = rf2 ? out2_e.pc        : '0;
  assign out2_npc       = rf2 ? out2_e.npc       : '0;
  assign out2_decodeout = rf2 ? out2_e.decodeout : '0;

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed stimulus plus a queue
// scoreboard whose monitor checks the DUT view every cycle.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in1_valid = 1'b0, in2_valid = 1'b0;
  logic [`PC_BUS]        in1_pc = '0, in2_pc = '0;
  logic [`PC_BUS]        in1_npc, in2_npc;
  logic [`DECODEOUT_BUS] in1_decodeout, in2_decodeout;
  logic                  in_ready;
  logic [`PC_BUS]        out1_pc, out1_npc, out2_pc, out2_npc;
  logic [`DECODEOUT_BUS] out1_decodeout, out2_decodeout;
  logic                  receive_flag1, receive_flag2;
  logic [1:0]            pop_num = 2'd0;
  logic                  stop = 1'b0, flush = 1'b0;

  int nchecks = 0;
  int nerr    = 0;
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] npc_of(input logic [31:0] p);
    return p + 32'h10;
  endfunction

  function automatic logic [63:0] dec_of(input logic [31:0] p);
    return {~p, p ^ 32'hA5A5_0000};
  endfunction

  assign in1_npc       = npc_of(in1_pc);
  assign in2_npc       = npc_of(in2_pc);
  assign in1_decodeout = dec_of(in1_pc);
  assign in2_decodeout = dec_of(in2_pc);

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in1_valid      (in1_valid),
    .in2_valid      (in2_valid),
    .in1_pc         (in1_pc),
    .in1_npc        (in1_npc),
    .in2_pc         (in2_pc),
    .in2_npc        (in2_npc),
    .in1_decodeout  (in1_decodeout),
    .in2_decodeout  (in2_decodeout),
    .in_ready       (in_ready),
    .out1_pc        (out1_pc),
    .out1_npc       (out1_npc),
    .out2_pc        (out2_pc),
    .out2_npc       (out2_npc),
    .out1_decodeout (out1_decodeout),
    .out2_decodeout (out2_decodeout),
    .receive_flag1  (receive_flag1),
    .receive_flag2  (receive_flag2),
    .pop_num        (pop_num),
    .stop           (stop),
    .flush          (flush)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks the DUT's view against the scoreboard mid-cycle, then
  // applies the push/pop that the upcoming edge will perform.
  initial begin : monitor
    int          cnt, push, pop, req, navail;
    bit          vf1, vf2;
    logic [31:0] vp1, vp2;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
      end else begin
        cnt  = exp_q.size();
        push = (cnt > int'(DEPTH) - 2 || flush || !in1_valid) ? 0 : (in2_valid ? 2 : 1);
        vf1  = (cnt >= 1);
        vf2  = (cnt >= 2);
        vp1  = vf1 ? exp_q[0] : 32'h0;
        vp2  = vf2 ? exp_q[1] : 32'h0;
`ifdef ISSUE_QUEUE_BYPASS_EN
        if (cnt == 0 && !flush) begin
          vf1 = (push >= 1);
          vf2 = (push == 2);
          vp1 = in1_pc;
          vp2 = in2_pc;
        end
`endif
        chk("mon_in_ready", 64'(in_ready), 64'(cnt <= int'(DEPTH) - 2));
        chk("mon_flag1", 64'(receive_flag1), 64'(vf1));
        chk("mon_flag2", 64'(receive_flag2), 64'(vf2));
        chk("mon_out1_pc", 64'(out1_pc), vf1 ? 64'(vp1) : 64'h0);
        chk("mon_out1_npc", 64'(out1_npc), vf1 ? 64'(npc_of(vp1)) : 64'h0);
        chk("mon_out1_dec", out1_decodeout, vf1 ? dec_of(vp1) : 64'h0);
        chk("mon_out2_pc", 64'(out2_pc), vf2 ? 64'(vp2) : 64'h0);
        chk("mon_out2_npc", 64'(out2_npc), vf2 ? 64'(npc_of(vp2)) : 64'h0);
        chk("mon_out2_dec", out2_decodeout, vf2 ? dec_of(vp2) : 64'h0);
        req    = (pop_num == 2'd3) ? 2 : int'(pop_num);
        navail = int'(vf1) + int'(vf2);
        pop    = (stop || flush) ? 0 : ((req < navail) ? req : navail);
        if (flush) begin
          exp_q.delete();
        end else begin
          if (push >= 1) exp_q.push_back(in1_pc);
          if (push == 2) exp_q.push_back(in2_pc);
          repeat (pop) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit v1, input bit v2, input logic [31:0] p1, input logic [31:0] p2,
                     input logic [1:0] pn, input bit st = 1'b0, input bit fl = 1'b0,
                     input bit r = 1'b1);
    in1_valid = v1; in2_valid = v2; in1_pc = p1; in2_pc = p2;
    pop_num = pn; stop = st; flush = fl; rst = r;
    @(posedge clk); #1;
    in1_valid = 1'b0; in2_valid = 1'b0; pop_num = 2'd0;
    stop = 1'b0; flush = 1'b0; rst = 1'b1;
  endtask

  initial begin : stimulus
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_flag1", 64'(receive_flag1), 64'h0);
    chk("rst_flag2", 64'(receive_flag2), 64'h0);
    chk("rst_out1_pc", 64'(out1_pc), 64'h0);
    chk("rst_out2_dec", out2_decodeout, 64'h0);

    cyc(1, 1, 32'h100, 32'h104, 0);
    chk("dual_flag1", 64'(receive_flag1), 64'h1);
    chk("dual_flag2", 64'(receive_flag2), 64'h1);
    chk("dual_out1_pc", 64'(out1_pc), 64'h100);
    chk("dual_out2_pc", 64'(out2_pc), 64'h104);
    cyc(0, 0, 0, 0, 2);
    chk("drain_flag1", 64'(receive_flag1), 64'h0);

    for (int i = 0; i < 4; i++) cyc(1, 1, 32'h200 + 8 * i, 32'h204 + 8 * i, 0);
    chk("full_in_ready", 64'(in_ready), 64'h0);
    cyc(1, 1, 32'h300, 32'h304, 0);
    chk("full_ignored_ready", 64'(in_ready), 64'h0);
    chk("full_out1_pc", 64'(out1_pc), 64'h200);
    cyc(0, 0, 0, 0, 2);
    chk("after_pop_ready", 64'(in_ready), 64'h1);
    chk("after_pop_out1_pc", 64'(out1_pc), 64'h208);

    cyc(1, 0, 32'h220, 0, 0);
    chk("cnt7_in_ready", 64'(in_ready), 64'h0);
    cyc(1, 1, 32'h500, 32'h504, 1);
    chk("cnt7_push_pop_ready", 64'(in_ready), 64'h1);
    chk("cnt7_push_pop_out1", 64'(out1_pc), 64'h20C);
    chk("cnt7_push_pop_out2", 64'(out2_pc), 64'h210);
    repeat (3) cyc(0, 0, 0, 0, 2);
    chk("drain2_flag1", 64'(receive_flag1), 64'h0);

    cyc(1, 0, 32'h400, 0, 0);
    chk("one_flag1", 64'(receive_flag1), 64'h1);
    chk("one_flag2", 64'(receive_flag2), 64'h0);
    cyc(0, 0, 0, 0, 2);
    chk("one_pop2_flag1", 64'(receive_flag1), 64'h0);
    chk("one_pop2_ready", 64'(in_ready), 64'h1);

    cyc(1, 1, 32'h600, 32'h604, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, 32'h608 + 8 * i, 32'h60C + 8 * i, 2);
    chk("wrap_out1_pc", 64'(out1_pc), 64'h6A0);
    chk("wrap_out2_pc", 64'(out2_pc), 64'h6A4);
    cyc(0, 0, 0, 0, 3);
    chk("pop3_flag1", 64'(receive_flag1), 64'h0);

    cyc(1, 1, 32'h700, 32'h704, 0);
    cyc(1, 1, 32'h708, 32'h70C, 0);
    cyc(1, 0, 32'h710, 0, 0);
    chk("cnt5_flag2", 64'(receive_flag2), 64'h1);
    cyc(1, 0, 32'h800, 0, 0, 1, 1);
    chk("flush_flag1", 64'(receive_flag1), 64'h0);
    chk("flush_flag2", 64'(receive_flag2), 64'h0);
    chk("flush_ready", 64'(in_ready), 64'h1);
    cyc(1, 0, 32'h900, 0, 0);
    chk("post_flush_out1", 64'(out1_pc), 64'h900);
    chk("post_flush_flag2", 64'(receive_flag2), 64'h0);
    cyc(1, 0, 32'h904, 0, 2, 1);
    chk("stop_out1", 64'(out1_pc), 64'h900);
    chk("stop_out2", 64'(out2_pc), 64'h904);

    cyc(1, 1, 32'hA00, 32'hA04, 1, 0, 0, 0);
    chk("midrst_flag1", 64'(receive_flag1), 64'h0);
    chk("midrst_out1_pc", 64'(out1_pc), 64'h0);
    chk("midrst_ready", 64'(in_ready), 64'h1);

`ifdef ISSUE_QUEUE_BYPASS_EN
    in1_valid = 1'b1; in2_valid = 1'b1; in1_pc = 32'h200; in2_pc = 32'h204; pop_num = 2'd1;
    #1;
    chk("bp_same_flag1", 64'(receive_flag1), 64'h1);
    chk("bp_same_out1", 64'(out1_pc), 64'h200);
    @(posedge clk); #1;
    in1_valid = 1'b0; in2_valid = 1'b0; pop_num = 2'd0;
    chk("bp_next_out1", 64'(out1_pc), 64'h204);
    chk("bp_next_flag2", 64'(receive_flag2), 64'h0);
    cyc(0, 0, 0, 0, 1);
`endif

    repeat (3) cyc(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of queue entries; power of two, at least 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 in1_valid / in2_valid  input  1 each  decode slot 1/2 holds an instruction; in2_valid honoured only with in1_valid.
REQ-005 in1_pc, in1_npc, in2_pc, in2_npc  input  `PC_BUS  pc and predicted next pc per slot.
REQ-006 in1_decodeout, in2_decodeout  input  `DECODEOUT_BUS  decoded instruction word per slot.
REQ-007 in_ready  output  1  queue accepts a two-instruction push this cycle.
REQ-008 out1_pc, out1_npc, out2_pc, out2_npc  output  `PC_BUS  oldest and second-oldest entry.
REQ-009 out1_decodeout, out2_decodeout  output  `DECODEOUT_BUS  decoded word of those entries.
REQ-010 receive_flag1 / receive_flag2  output  1 each  out1/out2 fields valid; these drive the launch stage's receive flags.
REQ-011 pop_num  input  2  number of entries launch consumed this cycle (0, 1, 2; 3 treated as 2).
REQ-012 stop  input  1  pipeline stall; forces effective pop to 0.
REQ-013 flush  input  1  branch redirect; discards all entries.

Function
REQ-014 Storage is circular; head and tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count log2(DEPTH)+1 bits.
REQ-015 in_ready SHALL equal (DEPTH - count >= 2), combinational from registered count.
REQ-016 Push count = 0 if !in_ready or flush or !in1_valid; else 1 + in2_valid; slot 1 written at tail, slot 2 at tail+1, in order.
REQ-017 receive_flag1 = (count >= 1), receive_flag2 = (count >= 2); out1 reads head, out2 reads head+1 (wrapped).
REQ-018 Output data fields SHALL be 0 when the corresponding receive flag is 0.
REQ-019 Effective pop = 0 if stop or flush; else min(pop_num clipped to 2, number of asserted receive flags).
REQ-020 Pop and push in the same cycle both apply; pops act on pre-push contents; count_next = count + push - pop; count never exceeds DEPTH nor underflows.
REQ-021 flush SHALL set head, tail, count to 0 next cycle and discard any same-cycle push; flush has priority over stop and push.
REQ-022 Latency push-to-visible is one cycle (without bypass); entries leave strictly in push order.
REQ-023 Full (count = DEPTH or DEPTH-1): in_ready low, inputs ignored, no overwrite; empty: both receive flags low, pop_num ignored.

Reset
REQ-024 rst low at a clock edge SHALL clear head, tail, count; in the following cycle receive_flag1/2 = 0, all output data = 0, in_ready = 1.
REQ-025 Reset mid-operation discards all entries and any same-cycle push; reset has priority over flush and stop; storage array is not cleared.

Configuration
REQ-026 Macro ISSUE_QUEUE_BYPASS_EN defined: when count = 0 and no flush, in1/in2 appear on out1/out2 in the same cycle with receive flags = in1_valid/in2_valid (push-qualified); bypassed entries popped that cycle are not written, unpopped ones are written.
REQ-027 Macro undefined: no combinational path from in* to out*/receive flags; latency per REQ-022.

Structure
REQ-028 `PC_BUS, `DECODEOUT_BUS and entry-width constants come from the shared def.vh; no local redefinition.
REQ-029 Storage SHALL be sub-module iq_entry_mem: DEPTH x (2*PC + DECODEOUT) bits, two write ports, two asynchronous read ports; pointer/count logic stays in issue_queue.

Verification
REQ-030 Reset, push pc 0x100/0x104 both valid, pop_num 0 -> next cycle receive_flag1/2 = 1, out1_pc 0x100, out2_pc 0x104, count 2.
REQ-031 Fill DEPTH=8 with 4 dual pushes -> in_ready 0 at count 8, fifth push ignored; pop_num 2 -> in_ready 1 next cycle, out1 = third entry.
REQ-032 count 1 with pop_num 2 -> only 1 popped, count 0, receive flags 0; simultaneous dual push + pop 1 at count 7 -> rejected push, count 6.
REQ-033 Pointer wrap: 20 cycles of push 2/pop 2 -> pc order preserved across head/tail wrap, no lost or duplicated entry.
REQ-034 flush with stop=1, in1_valid=1, count 5 -> next cycle count 0, receive flags 0, flushed push absent.
REQ-035 With ISSUE_QUEUE_BYPASS_EN, empty queue, push 0x200/0x204, pop_num 1 -> same-cycle out1_pc 0x200; next cycle out1_pc 0x204, count 1.
